// File: rtl/parking_gate_scheduler.sv
// Boom-gate scheduler for the shared parking lane.
// Four requesters (car in, bike in, car out, bike out) are served round-robin.
// Entry is refused when that vehicle class is full, and exit is refused when it is empty.
// Each service opens the gate and waits for the pass sensor. The service ends with one
// count pulse on a pass, an error pulse on a timeout, or no pulse when the request is withdrawn.
module parking_gate_scheduler #(
    parameter int CNT_W         = 8,
    parameter int CAR_CAPACITY  = 50,
    parameter int BIKE_CAPACITY = 100,
    parameter int PASS_TIMEOUT  = 255,
    parameter int CLOSE_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_in_req,
    input  logic             bike_in_req,
    input  logic             car_out_req,
    input  logic             bike_out_req,
    input  logic             pass_sensor,
    input  logic [CNT_W-1:0] cars_in_parking,
    input  logic [CNT_W-1:0] bikes_in_parking,
    output logic             gate_open,
    output logic [3:0]       grant,
    output logic             car_entry,
    output logic             bike_entry,
    output logic             car_exit,
    output logic             bike_exit,
    output logic             car_full,
    output logic             bike_full,
    output logic             timeout_err
);

    localparam int TMR_W = $clog2(PASS_TIMEOUT + 1);
    localparam int CLS_W = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CAR_CAP   = CNT_W'(CAR_CAPACITY);
    localparam logic [CNT_W-1:0] BIKE_CAP  = CNT_W'(BIKE_CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(PASS_TIMEOUT - 1);
    localparam logic [CLS_W-1:0] CLS_LAST  = CLS_W'(CLOSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        CLOSING = 2'd2
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [CLS_W-1:0] close_cnt;
    logic [1:0]       ptr;
    logic [3:0]       pulse_q;

    logic [3:0]       req;
    logic [3:0]       eligible;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic             found;

    assign car_full  = (cars_in_parking >= CAR_CAP);
    assign bike_full = (bikes_in_parking >= BIKE_CAP);

    assign req = {bike_out_req, car_out_req, bike_in_req, car_in_req};

    assign eligible[0] = car_in_req  & ~car_full;
    assign eligible[1] = bike_in_req & ~bike_full;
    assign eligible[2] = car_out_req  & (cars_in_parking  != '0);
    assign eligible[3] = bike_out_req & (bikes_in_parking != '0);

    assign car_entry  = pulse_q[0];
    assign bike_entry = pulse_q[1];
    assign car_exit   = pulse_q[2];
    assign bike_exit  = pulse_q[3];

    // Round-robin pick: the first eligible index at or after the pointer, wrapping mod 4
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Gate FSM with registered outputs; count and error pulses last only one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gate_open   <= 1'b0;
            grant       <= '0;
            pulse_q     <= '0;
            timeout_err <= 1'b0;
            timer       <= '0;
            close_cnt   <= '0;
            ptr         <= '0;
        end else begin
            pulse_q     <= '0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= OPEN;
                        gate_open <= 1'b1;
                        grant     <= 4'b0001 << winner;
                        timer     <= '0;
                        ptr       <= winner + 2'd1;
                    end
                end
                OPEN: begin
                    if ((grant & req) == 4'b0000) begin
                        state     <= CLOSING;
                        gate_open <= 1'b0;
                        grant     <= '0;
                        close_cnt <= '0;
                    end else if (pass_sensor) begin
                        state     <= CLOSING;
                        gate_open <= 1'b0;
                        grant     <= '0;
                        close_cnt <= '0;
                        pulse_q   <= grant;
                    end else if (timer == TMR_LAST) begin
                        state       <= CLOSING;
                        gate_open   <= 1'b0;
                        grant       <= '0;
                        close_cnt   <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CLOSING: begin
                    if (close_cnt == CLS_LAST) begin
                        state <= IDLE;
                    end else begin
                        close_cnt <= close_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gate_open <= 1'b0;
                    grant     <= '0;
                end
            endcase
        end
    end

endmodule
